// File: rtl/wishbone_power_sequencer.sv
// Wishbone slave that applies requested per-daughter power/drive states one daughter at a time with settle waits.
// Optional fault inputs, 2-FF synchronised, are enabled by defining WB_POWER_FAULT_EN.
module wishbone_power_sequencer #(
  parameter int NUM_DAUGHTERS  = 4,
  parameter int SETTLE_DEFAULT = 100,
  parameter int PRESCALE_LOG2  = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       wr_i,
  input  logic [15:0]                adr_i,
  input  logic [7:0]                 dat_i,
  output logic [7:0]                 dat_o,
  output logic                       ack_o,
  output logic                       err_o,
  output logic                       rty_o,
  output logic [4*NUM_DAUGHTERS-1:0] power_o,
  output logic [4*NUM_DAUGHTERS-1:0] drive_o,
`ifdef WB_POWER_FAULT_EN
  input  logic [NUM_DAUGHTERS-1:0]   fault_i,
`endif
  output logic                       busy_o
);

  localparam int         MAXD = 8;
  localparam int         CW   = 8 + PRESCALE_LOG2;
  localparam logic [2:0] LAST = 3'(NUM_DAUGHTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_DRV_OFF, S_PWR, S_DRV_ON, S_NEXT, S_WAIT
  } state_t;

  state_t               state, state_nx, ret, ret_nx;
  logic [7:0]           req [MAXD];
  logic [MAXD-1:0][3:0] pwr_app, drv_app;
  logic [7:0]           snap, settle, rd;
  logic [2:0]           idx, idx_nx, pick;
  logic [3:0]           j;
  logic [CW-1:0]        cnt;
  logic [MAXD-1:0]      fault_s, mism;
  logic [7:0]           fault_reg;
  logic                 we, any_mism;
  logic                 snap_ld, drv_off_ld, pwr_ld, drv_on_ld, cnt_ld;
  logic [3:0]           snap_eff, cur_drv, cur_pwr, drv_off_val, pwr_new_on;
  logic                 unused_ok;

  assign we          = cyc_i & stb_i & wr_i;
  assign ack_o       = cyc_i & stb_i;
  assign err_o       = 1'b0;
  assign rty_o       = 1'b0;
  assign busy_o      = (state != S_IDLE);
  assign power_o     = pwr_app[NUM_DAUGHTERS-1:0];
  assign drive_o     = drv_app[NUM_DAUGHTERS-1:0];
  assign dat_o       = rd;
  assign unused_ok   = &{1'b0, adr_i[15:4]};

  assign snap_eff    = snap[7:4] & snap[3:0];
  assign cur_drv     = drv_app[idx];
  assign cur_pwr     = pwr_app[idx];
  assign drv_off_val = cur_drv & snap_eff;
  assign pwr_new_on  = snap[3:0] & ~cur_pwr;

`ifdef WB_POWER_FAULT_EN
  logic [NUM_DAUGHTERS-1:0] f_meta, f_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_meta    <= '0;
      f_sync    <= '0;
      fault_reg <= '0;
    end else begin
      f_meta <= fault_i;
      f_sync <= f_meta;
      for (int d = 0; d < NUM_DAUGHTERS; d++) begin
        // A fault arriving in the same cycle as a clear stays latched.
        if (we && adr_i[3:0] == 4'h9 && dat_i[d]) fault_reg[d] <= 1'b0;
        if (fault_s[d]) fault_reg[d] <= 1'b1;
      end
    end
  end

  assign fault_s = MAXD'(f_sync);
`else
  assign fault_s   = '0;
  assign fault_reg = '0;
`endif

  always_comb begin
    for (int d = 0; d < MAXD; d++) begin
      mism[d] = (d < NUM_DAUGHTERS) &&
                ((pwr_app[d] != req[d][3:0]) || (drv_app[d] != (req[d][7:4] & req[d][3:0])));
    end
  end

  // Walk offsets from the highest down so the nearest slot at or after idx wins.
  always_comb begin
    any_mism = 1'b0;
    pick     = idx;
    j        = '0;
    for (int k = NUM_DAUGHTERS - 1; k >= 0; k--) begin
      j = {1'b0, idx} + 4'(k);
      if (j >= 4'(NUM_DAUGHTERS)) j = j - 4'(NUM_DAUGHTERS);
      if (mism[j[2:0]]) begin
        any_mism = 1'b1;
        pick     = j[2:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      ret   <= S_IDLE;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ret_nx     = ret;
    idx_nx     = idx;
    snap_ld    = 1'b0;
    drv_off_ld = 1'b0;
    pwr_ld     = 1'b0;
    drv_on_ld  = 1'b0;
    cnt_ld     = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_mism) begin
          idx_nx   = pick;
          state_nx = S_SNAP;
        end
      end
      S_SNAP: begin
        snap_ld  = 1'b1;
        state_nx = S_DRV_OFF;
      end
      S_DRV_OFF: begin
        drv_off_ld = 1'b1;
        if (drv_off_val != cur_drv) begin
          cnt_ld   = 1'b1;
          ret_nx   = S_PWR;
          state_nx = S_WAIT;
        end else begin
          state_nx = S_PWR;
        end
      end
      S_PWR: begin
        pwr_ld = 1'b1;
        if (|pwr_new_on) begin
          cnt_ld   = 1'b1;
          ret_nx   = S_DRV_ON;
          state_nx = S_WAIT;
        end else begin
          state_nx = S_DRV_ON;
        end
      end
      S_DRV_ON: begin
        drv_on_ld = 1'b1;
        state_nx  = S_NEXT;
      end
      S_NEXT: begin
        idx_nx   = (idx == LAST) ? 3'd0 : idx + 3'd1;
        state_nx = S_IDLE;
      end
      S_WAIT: begin
        if (cnt <= CW'(1)) state_nx = ret;
      end
      default: state_nx = S_IDLE;
    endcase
    if (fault_s[idx] && state != S_IDLE && state != S_NEXT) begin
      state_nx   = S_NEXT;
      snap_ld    = 1'b0;
      drv_off_ld = 1'b0;
      pwr_ld     = 1'b0;
      drv_on_ld  = 1'b0;
      cnt_ld     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int d = 0; d < MAXD; d++) req[d] <= '0;
      pwr_app <= '0;
      drv_app <= '0;
      snap    <= '0;
      settle  <= 8'(SETTLE_DEFAULT);
      idx     <= '0;
      cnt     <= '0;
    end else begin
      idx <= idx_nx;
      if (snap_ld) snap <= req[idx];
      // The count is captured on WAIT entry, so SETTLE writes only affect later waits.
      if (cnt_ld) cnt <= CW'(settle) << PRESCALE_LOG2;
      else if (state == S_WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (drv_off_ld) drv_app[idx] <= drv_off_val;
      if (pwr_ld) pwr_app[idx] <= snap[3:0];
      if (drv_on_ld) drv_app[idx] <= snap_eff;
      if (we && adr_i[3:0] == 4'hA) settle <= dat_i;
      for (int d = 0; d < MAXD; d++) begin
        if (d < NUM_DAUGHTERS) begin
          if (we && adr_i[3:0] == 4'(d) && !fault_s[d]) req[d] <= dat_i;
          if (fault_s[d]) begin
            req[d]     <= '0;
            pwr_app[d] <= '0;
            drv_app[d] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int d = 0; d < NUM_DAUGHTERS; d++) begin
      if (adr_i[3:0] == 4'(d)) rd = req[d];
    end
    case (adr_i[3:0])
      4'h8:    rd = {4'b0, idx, busy_o};
      4'h9:    rd = fault_reg;
      4'hA:    rd = settle;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_power_sequencer.sv
// Scoreboard bench for wishbone_power_sequencer: expected output transitions and their spacing are queued
// as requests are written and matched against every observed change of power_o/drive_o.
module tb_wishbone_power_sequencer;
  localparam int N = 4;
  localparam int P = 2;

  logic          clk = 1'b0;
  logic          rst, cyc, stb, wr;
  logic [15:0]   adr;
  logic [7:0]    dat_w, dat_r;
  logic          ack, err, rty, busy;
  logic [4*N-1:0] power, drive;
`ifdef WB_POWER_FAULT_EN
  logic [N-1:0]  fault = '0;
`endif

  wishbone_power_sequencer #(.NUM_DAUGHTERS(N), .SETTLE_DEFAULT(100), .PRESCALE_LOG2(P)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .wr_i(wr), .adr_i(adr), .dat_i(dat_w),
    .dat_o(dat_r), .ack_o(ack), .err_o(err), .rty_o(rty), .power_o(power), .drive_o(drive),
`ifdef WB_POWER_FAULT_EN
    .fault_i(fault),
`endif
    .busy_o(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pwr;
    logic [15:0] drv;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc_cnt = 0, last_change = 0;
  logic [31:0] prev = '0;
  logic [7:0]  rv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic void push(input logic [15:0] p, input logic [15:0] d, input int g);
    exp_t e;
    e.pwr = p; e.drv = d; e.gap = g;
    exp_q.push_back(e);
  endfunction

  // Gap = cycles since the previous output change; -1 means not timed.
  always @(negedge clk) begin
    exp_t e;
    cyc_cnt++;
    if ({power, drive} != prev) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {power, drive}, prev);
      end else begin
        e = exp_q.pop_front();
        check("sb_power", 32'(power), 32'(e.pwr));
        check("sb_drive", 32'(drive), 32'(e.drv));
        if (e.gap >= 0) check("sb_gap", cyc_cnt - last_change, e.gap);
      end
      last_change = cyc_cnt;
      prev = {power, drive};
    end
  end

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wr = 1'b1; adr = {12'h0, a}; dat_w = d;
    #1 check("ack_wr", ack, 1'b1);
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0; wr = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wr = 1'b0; adr = {12'h0, a};
    #1 d = dat_r;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while ((exp_q.size() != 0 || busy) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; wr = 1'b0; adr = '0; dat_w = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_power", power, 0);
    check("rst_drive", drive, 0);
    check("rst_busy", busy, 0);
    check("err_rty", {err, rty}, 0);
    wb_read(4'hA, rv); check("rst_settle", rv, 100);
    wb_read(4'h8, rv); check("rst_status", rv, 0);
    wb_read(4'h9, rv); check("rst_fault", rv, 0);
    wb_read(4'h0, rv); check("rst_req0", rv, 0);

    wb_write(4'hA, 8'd2);
    wb_read(4'hA, rv); check("settle_rw", rv, 2);
    wb_write(4'h5, 8'hFF);
    wb_read(4'h5, rv); check("req_oob", rv, 0);
    wb_write(4'hB, 8'h55);
    wb_read(4'hB, rv); check("unmapped", rv, 0);

    // Power on; drive follows after an 8-cycle WAIT plus the DRV_ON cycle.
    push(16'h0001, 16'h0000, -1);
    push(16'h0001, 16'h0001, 2 * 4 + 1);
    wb_write(4'h0, 8'h11);
    drain("t1");

    // Drive off first, power off after the wait plus the PWR cycle.
    push(16'h0001, 16'h0000, -1);
    push(16'h0000, 16'h0000, 2 * 4 + 1);
    wb_write(4'h0, 8'h00);
    drain("t2");

    // Drive without power is not an effective request: nothing happens.
    wb_write(4'h1, 8'hF0);
    repeat (3) @(negedge clk);
    check("t3_busy", busy, 0);
    wb_read(4'h1, rv); check("t3_req1", rv, 8'hF0);

    // Two daughters in one pass: d0 then d2 (idx starts at 1, wraps to 0).
    // Gap: WAIT 8 + DRV_ON + NEXT + IDLE + SNAP + DRV_OFF + PWR = 14.
    push(16'h000F, 16'h0000, -1);
    push(16'h0F0F, 16'h0000, 14);
    wb_write(4'h0, 8'h0F);
    wb_write(4'h2, 8'h0F);
    wb_read(4'h8, rv); check("t4_status_d0", rv, 8'h01);
    for (int i = 0; i < 200 && !power[8]; i++) @(negedge clk);
    wb_read(4'h8, rv); check("t4_status_d2", rv, 8'h05);
    drain("t4");

    // SETTLE=0 collapses the wait to a single cycle.
    wb_write(4'hA, 8'd0);
    push(16'h0F1F, 16'h0000, -1);
    push(16'h0F1F, 16'h0010, 2);
    wb_write(4'h1, 8'h11);
    drain("settle0");

    // Reset during WAIT drops everything immediately.
    wb_write(4'hA, 8'd2);
    push(16'h1F1F, 16'h0010, -1);
    wb_write(4'h3, 8'h01);
    for (int i = 0; i < 200 && !power[12]; i++) @(negedge clk);
    check("t5_pwr_on", power[12], 1'b1);
    repeat (2) @(posedge clk);
    #2;
    check("t5_busy_before", busy, 1'b1);
    push(16'h0000, 16'h0000, -1);
    rst = 1'b1;
    #1;
    check("t5_power", power, 0);
    check("t5_drive", drive, 0);
    check("t5_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    wb_read(4'hA, rv); check("t5_settle", rv, 100);
    wb_read(4'h3, rv); check("t5_req3", rv, 0);

`ifdef WB_POWER_FAULT_EN
    wb_write(4'hA, 8'd0);
    push(16'h3000, 16'h0000, -1);
    push(16'h3000, 16'h3000, 2);
    wb_write(4'h3, 8'h33);
    drain("t6_on");
    push(16'h0000, 16'h0000, -1);
    @(negedge clk);
    fault = 4'h8;
    @(negedge clk);
    fault = 4'h0;
    @(posedge clk);
    #1 check("t6_still_on", power[15:12], 4'h3);
    @(posedge clk);
    #1 check("t6_cleared", power[15:12], 4'h0);
    check("t6_drive_cleared", drive[15:12], 4'h0);
    wb_read(4'h9, rv); check("t6_fault", rv, 8'h08);
    wb_read(4'h3, rv); check("t6_req3", rv, 0);
    wb_write(4'h9, 8'h08);
    wb_read(4'h9, rv); check("t6_fault_clr", rv, 8'h00);
`endif

    repeat (20) @(negedge clk);
    check("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
